ibex_rvfi_trace_buf: RTL and testbench
======================================

Name: ibex_rvfi_trace_buf

Overview:
On-core retirement trace capture buffer. It sits beside ibex_top alongside the RVFI tracer, snoops the RVFI retirement port, and packs each retired instruction into a 128-bit record. Records go into a Depth-entry ring buffer, with stop-when-full or wrap modes and an optional PC trigger with post-trigger count. A valid/ready port of configurable width drains the buffer to a debug or test harness.

Parameters:
- Depth, 64: number of 128-bit records stored. Power of 2, >= 4.
- OutWidth, 32: drain beat width. Legal values 32, 64 or 128. BeatsPerRec = 128/OutWidth.
- DropCntW, 16: width of the saturating drop counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- rvfi_valid_i  in  1  retirement strobe.
- rvfi_order_i  in  64  retirement order.
- rvfi_insn_i  in  32  instruction word.
- rvfi_pc_rdata_i  in  32  PC of the retired instruction.
- rvfi_rd_addr_i  in  5  destination register.
- rvfi_rd_wdata_i  in  32  destination write data.
- rvfi_trap_i / rvfi_halt_i / rvfi_intr_i  in  1 each  retirement flags.
- rvfi_mode_i  in  2  privilege mode.
- ctl_start_i  in  1  pulse: clear the buffer and arm capture.
- ctl_wrap_i  in  1  0 = stop-when-full, 1 = overwrite oldest.
- ctl_trig_en_i  in  1  enable the PC trigger.
- ctl_trig_pc_i  in  32  trigger PC.
- ctl_post_cnt_i  in  $clog2(Depth)+1  records to capture after the trigger record.
- out_valid_o  out  1  drain beat valid.
- out_ready_i  in  1  drain beat accept.
- out_data_o  out  OutWidth  drain beat data.
- out_last_o  out  1  final beat of a record.
- state_o  out  2  FSM state (IDLE=0, ARMED=1, POST=2, DONE=3).
- count_o  out  $clog2(Depth)+1  records held.
- drop_cnt_o  out  DropCntW  records dropped, saturating.
- triggered_o  out  1  trigger has fired since the last start.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values: state IDLE, count_o=0, drop_cnt_o=0, triggered_o=0, out_valid_o=0, out_last_o=0, out_data_o=0. Pointers and beat index are 0. Storage contents are don't-care.
- Record layout, with word0 drained first:
  - word0 = pc.
  - word1 = insn.
  - word2 = rd_wdata.
  - word3 = {trap, intr, halt, mode[1:0], rd_addr[4:0], order[21:0]}, MSB first.
- Capture: occurs only in ARMED or POST, and only when rvfi_valid_i=1. The record is written at the rising edge. count_o reflects it at T+1, and out_valid_o may rise at T+1 at the earliest.
- FSM transitions:
  - ctl_start_i in any state clears pointers, count, drop_cnt and triggered, then enters ARMED. A capture in that same cycle is ignored.
  - ARMED, trig_en=1, retiring pc == ctl_trig_pc_i: the trigger record is captured and triggered_o is set. If post_cnt==0, go to DONE; else load the post counter with post_cnt and go to POST.
  - POST: each captured record decrements the counter; reaching 0 enters DONE. A record dropped in POST also decrements the counter.
  - DONE and IDLE capture nothing. Only ctl_start_i leaves them.
- Full, ctl_wrap_i=0: an incoming record is dropped and drop_cnt is incremented.
- Full, ctl_wrap_i=1: the incoming record overwrites the oldest; the read pointer advances and count is unchanged.
  - Exception: if the oldest record already has at least one beat accepted, the incoming record is dropped and drop_cnt is incremented.
- Simultaneous push and pop when full: if the last beat of the oldest record is accepted in the same cycle as a capture, the push succeeds, count is unchanged and nothing is dropped.
- drop_cnt saturates at all-ones.
- Drain availability: permitted in IDLE and DONE, and in ARMED/POST only when ctl_trig_en_i=0 (streaming). Otherwise out_valid_o=0.
- Drain beats:
  - out_valid_o=1 whenever drain is permitted and count>0.
  - out_data_o is beat k of the oldest record, low word first.
  - out_data_o and out_last_o are held stable while valid && !ready.
  - A beat completes on valid && ready. out_last_o=1 on beat BeatsPerRec-1; completing it pops the record.
- Pointers: wrap modulo Depth and carry an extra bit for the full/empty distinction.
- Reset mid-operation: abandons any partial record drain. The next cycle shows reset values.

Decomposition:
- Package ibex_trace_pkg holds:
  - TRACE_REC_W=128.
  - trace_rec_t, a packed struct in word3..word0 order.
  - trace_state_e.
  - The function pack_rec(), which builds a record from the RVFI fields.
- Sub-module ibex_trace_ring holds the Depth x 128 storage, read/write pointers, count, the overwrite-oldest push and the beat-indexed read mux.
- The top level holds the FSM, trigger compare, post counter, drop counter and drain handshake.

Test Plan:
- Stream and drain: Depth=8, OutWidth=32, wrap=0, trig_en=0. Start, then retire pc 0x100, 0x104, 0x108 → count_o=3. Drain with ready=1 gives 12 beats: beat0=0x100, beat4=0x104; out_last_o on beats 3, 7, 11; count_o=0 afterwards.
- Stop-when-full: Depth=8, wrap=0, no drain, 10 retirements with order 0..9 → count_o=8, drop_cnt_o=2. Drained word3 order fields are 0..7.
- Wrap: same stimulus with wrap=1 → count_o=8, drop_cnt_o=0. The first drained record has order 2.
- Trigger: trig_en=1, trig_pc=0x200, post_cnt=2. Retire 0x1F8, 0x1FC, 0x200, 0x204, 0x208, 0x20C.
  - triggered_o=1 and state POST the cycle after 0x200; DONE the cycle after 0x208.
  - 0x20C is not captured and count_o=5.
  - The last drained record has pc=0x208.
- Full push and pop: Depth=8, wrap=0, full. Assert rvfi_valid_i in the same cycle as the last-beat handshake → count_o stays 8, drop_cnt_o=0, and the new record is drained last. Hold ready=0 for 3 cycles mid-record → out_data_o is unchanged.
- Reset mid-drain: rst_ni=0 for one cycle during beat 2 → next cycle out_valid_o=0, count_o=0, state_o=IDLE, drop_cnt_o=0.

Source files
------------

// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI retirement trace buffer: record layout, FSM states
// and the record packing helper.
package ibex_trace_pkg;

   localparam int TRACE_REC_W = 128;

   // word0 sits in the low 32 bits so it is the first beat drained.
   typedef struct packed {
      logic [31:0] word3;
      logic [31:0] word2;
      logic [31:0] word1;
      logic [31:0] word0;
   } trace_rec_t;

   typedef enum logic [1:0] {
      TS_IDLE  = 2'd0,
      TS_ARMED = 2'd1,
      TS_POST  = 2'd2,
      TS_DONE  = 2'd3
   } trace_state_e;

   function automatic trace_rec_t pack_rec(
      input logic [31:0] pc,
      input logic [31:0] insn,
      input logic [31:0] rd_wdata,
      input logic [4:0]  rd_addr,
      input logic [21:0] order_lo,
      input logic        trap,
      input logic        intr,
      input logic        halt,
      input logic [1:0]  mode
   );
      trace_rec_t rec;
      rec.word0 = pc;
      rec.word1 = insn;
      rec.word2 = rd_wdata;
      rec.word3 = {trap, intr, halt, mode, rd_addr, order_lo};
      return rec;
   endfunction

endpackage

// File: rtl/ibex_rvfi_trace_buf_if.sv
// Bundle of RVFI snoop, control, drain and status signals for the trace buffer.
interface ibex_rvfi_trace_buf_if #(
   parameter int Depth    = 64,
   parameter int OutWidth = 32,
   parameter int DropCntW = 16
);
   localparam int CntW = $clog2(Depth) + 1;

   logic                rvfi_valid_i;
   logic [63:0]         rvfi_order_i;
   logic [31:0]         rvfi_insn_i;
   logic [31:0]         rvfi_pc_rdata_i;
   logic [4:0]          rvfi_rd_addr_i;
   logic [31:0]         rvfi_rd_wdata_i;
   logic                rvfi_trap_i;
   logic                rvfi_halt_i;
   logic                rvfi_intr_i;
   logic [1:0]          rvfi_mode_i;
   logic                ctl_start_i;
   logic                ctl_wrap_i;
   logic                ctl_trig_en_i;
   logic [31:0]         ctl_trig_pc_i;
   logic [CntW-1:0]     ctl_post_cnt_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [OutWidth-1:0] out_data_o;
   logic                out_last_o;
   logic [1:0]          state_o;
   logic [CntW-1:0]     count_o;
   logic [DropCntW-1:0] drop_cnt_o;
   logic                triggered_o;

   modport master (
      output rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_pc_rdata_i, rvfi_rd_addr_i,
             rvfi_rd_wdata_i, rvfi_trap_i, rvfi_halt_i, rvfi_intr_i, rvfi_mode_i,
             ctl_start_i, ctl_wrap_i, ctl_trig_en_i, ctl_trig_pc_i, ctl_post_cnt_i,
             out_ready_i,
      input  out_valid_o, out_data_o, out_last_o, state_o, count_o, drop_cnt_o,
             triggered_o
   );

   modport slave (
      input  rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_pc_rdata_i, rvfi_rd_addr_i,
             rvfi_rd_wdata_i, rvfi_trap_i, rvfi_halt_i, rvfi_intr_i, rvfi_mode_i,
             ctl_start_i, ctl_wrap_i, ctl_trig_en_i, ctl_trig_pc_i, ctl_post_cnt_i,
             out_ready_i,
      output out_valid_o, out_data_o, out_last_o, state_o, count_o, drop_cnt_o,
             triggered_o
   );

endinterface

// File: rtl/ibex_trace_ring.sv
// Depth x 128-bit record ring with extra-bit pointers, overwrite-oldest push
// and a beat-indexed read of the oldest record.
module ibex_trace_ring
   import ibex_trace_pkg::*;
#(
   parameter int Depth    = 64,
   parameter int OutWidth = 32,
   localparam int AW      = $clog2(Depth),
   localparam int CntW    = AW + 1,
   localparam int Beats   = TRACE_REC_W / OutWidth,
   localparam int BW      = (Beats > 1) ? $clog2(Beats) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                push_i,
   input  logic                wrap_i,
   input  logic                beat_busy_i,
   input  logic                pop_i,
   input  logic [BW-1:0]       beat_idx_i,
   input  trace_rec_t          rec_i,
   output logic [CntW-1:0]     count_o,
   output logic                push_drop_o,
   output logic [OutWidth-1:0] beat_data_o
);

   trace_rec_t mem [Depth];
   logic [AW:0] wr_q, rd_q;
   logic        full, overwrite, wr_en, rd_adv;
   logic [Beats-1:0][OutWidth-1:0] head_beats;

   assign count_o = wr_q - rd_q;
   assign full    = (count_o == CntW'(Depth));

   // A partly drained head must not be replaced under the consumer, so a
   // wrap push against it is dropped instead of overwriting.
   assign overwrite   = push_i && full && !pop_i && wrap_i && !beat_busy_i;
   assign wr_en       = push_i && (!full || pop_i || overwrite);
   assign rd_adv      = pop_i || overwrite;
   assign push_drop_o = push_i && !wr_en;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (clear_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en)  wr_q <= wr_q + 1'b1;
         if (rd_adv) rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_q[AW-1:0]] <= rec_i;
   end

   assign head_beats  = mem[rd_q[AW-1:0]];
   assign beat_data_o = head_beats[beat_idx_i];

endmodule

// File: rtl/ibex_rvfi_trace_buf.sv
// RVFI retirement trace capture: FSM, PC trigger, post-trigger down-counter,
// saturating drop counter and the beat-wise drain handshake.
//
// state    | meaning
// TS_IDLE  | after reset, nothing captured, drain allowed
// TS_ARMED | capturing, waiting for the trigger PC (if enabled)
// TS_POST  | trigger seen, capturing the post-trigger records
// TS_DONE  | capture finished, drain allowed until the next start
module ibex_rvfi_trace_buf
   import ibex_trace_pkg::*;
#(
   parameter int Depth    = 64,
   parameter int OutWidth = 32,
   parameter int DropCntW = 16
) (
   input logic clk_i,
   input logic rst_ni,
   ibex_rvfi_trace_buf_if.slave bus
);

   localparam int CntW  = $clog2(Depth) + 1;
   localparam int Beats = TRACE_REC_W / OutWidth;
   localparam int BW    = (Beats > 1) ? $clog2(Beats) : 1;

   trace_state_e        state_q, state_d;
   logic [CntW-1:0]     post_q, post_d;
   logic                triggered_q, triggered_d;
   logic [DropCntW-1:0] drop_q;
   logic [BW-1:0]       beat_q;
   logic [CntW-1:0]     count;
   logic [OutWidth-1:0] beat_data;
   trace_rec_t          rec;
   logic                capture, trig_hit, drain_ok, beat_done, last_beat, rec_done;
   logic                push_drop;
   logic                unused_order_hi;

   assign unused_order_hi = ^bus.rvfi_order_i[63:22];

   assign rec = pack_rec(bus.rvfi_pc_rdata_i, bus.rvfi_insn_i, bus.rvfi_rd_wdata_i,
                         bus.rvfi_rd_addr_i, bus.rvfi_order_i[21:0], bus.rvfi_trap_i,
                         bus.rvfi_intr_i, bus.rvfi_halt_i, bus.rvfi_mode_i);

   assign capture  = bus.rvfi_valid_i && !bus.ctl_start_i &&
                     (state_q == TS_ARMED || state_q == TS_POST);
   assign trig_hit = capture && (state_q == TS_ARMED) && bus.ctl_trig_en_i &&
                     (bus.rvfi_pc_rdata_i == bus.ctl_trig_pc_i);

   // While a trigger is pending or counting out, the buffer is held intact.
   assign drain_ok  = (state_q == TS_IDLE) || (state_q == TS_DONE) || !bus.ctl_trig_en_i;
   assign last_beat = (beat_q == BW'(Beats - 1));
   assign beat_done = bus.out_valid_o && bus.out_ready_i;
   assign rec_done  = beat_done && last_beat;

   assign bus.out_valid_o = drain_ok && (count != '0);
   assign bus.out_last_o  = bus.out_valid_o && last_beat;
   assign bus.out_data_o  = bus.out_valid_o ? beat_data : '0;
   assign bus.state_o     = state_q;
   assign bus.count_o     = count;
   assign bus.drop_cnt_o  = drop_q;
   assign bus.triggered_o = triggered_q;

   ibex_trace_ring #(
      .Depth    (Depth),
      .OutWidth (OutWidth)
   ) u_ring (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (bus.ctl_start_i),
      .push_i      (capture),
      .wrap_i      (bus.ctl_wrap_i),
      .beat_busy_i (beat_q != '0),
      .pop_i       (rec_done),
      .beat_idx_i  (beat_q),
      .rec_i       (rec),
      .count_o     (count),
      .push_drop_o (push_drop),
      .beat_data_o (beat_data)
   );

   always_comb begin
      state_d     = state_q;
      post_d      = post_q;
      triggered_d = triggered_q;
      if (bus.ctl_start_i) begin
         state_d     = TS_ARMED;
         post_d      = '0;
         triggered_d = 1'b0;
      end else begin
         case (state_q)
            TS_ARMED: begin
               if (trig_hit) begin
                  triggered_d = 1'b1;
                  if (bus.ctl_post_cnt_i == '0) begin
                     state_d = TS_DONE;
                  end else begin
                     post_d  = bus.ctl_post_cnt_i;
                     state_d = TS_POST;
                  end
               end
            end
            // Dropped records count against the post window as well.
            TS_POST: begin
               if (capture) begin
                  post_d = post_q - 1'b1;
                  if (post_q == CntW'(1)) state_d = TS_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= TS_IDLE;
         post_q      <= '0;
         triggered_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         post_q      <= post_d;
         triggered_q <= triggered_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         drop_q <= '0;
         beat_q <= '0;
      end else if (bus.ctl_start_i) begin
         drop_q <= '0;
         beat_q <= '0;
      end else begin
         if (push_drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
         if (beat_done) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the trace buffer.
module tb_ibex_rvfi_trace_buf;

   localparam int DEPTH = 8;
   localparam int OW    = 32;
   localparam int DW    = 16;
   localparam int BPR   = 128 / OW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ibex_rvfi_trace_buf_if #(.Depth(DEPTH), .OutWidth(OW), .DropCntW(DW)) bus ();

   ibex_rvfi_trace_buf #(.Depth(DEPTH), .OutWidth(OW), .DropCntW(DW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   // reference model: records held oldest-first, plus drain/capture status
   logic [127:0] mq [$];
   int m_state = 0;
   int m_post  = 0;
   int m_trig  = 0;
   int m_drops = 0;
   int m_k     = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_valid();
      return ((m_state == 0) || (m_state == 3) || !bus.ctl_trig_en_i) && (mq.size() > 0);
   endfunction

   function automatic logic [31:0] m_beat();
      logic [127:0] r;
      r = mq[0];
      return r[m_k*OW +: OW];
   endfunction

   function automatic logic [127:0] cur_rec();
      logic [31:0] w3;
      w3 = {bus.rvfi_trap_i, bus.rvfi_intr_i, bus.rvfi_halt_i, bus.rvfi_mode_i,
            bus.rvfi_rd_addr_i, bus.rvfi_order_i[21:0]};
      return {w3, bus.rvfi_rd_wdata_i, bus.rvfi_insn_i, bus.rvfi_pc_rdata_i};
   endfunction

   task automatic model_edge();
      bit hs, popr, cap, full;
      hs   = m_valid() && bus.out_ready_i;
      popr = hs && (m_k == BPR - 1);
      if (!rst_n) begin
         mq.delete(); m_state = 0; m_post = 0; m_trig = 0; m_drops = 0; m_k = 0;
      end else if (bus.ctl_start_i) begin
         mq.delete(); m_state = 1; m_trig = 0; m_drops = 0; m_k = 0;
      end else begin
         cap  = ((m_state == 1) || (m_state == 2)) && bus.rvfi_valid_i;
         full = (mq.size() == DEPTH);
         if (popr) void'(mq.pop_front());
         if (cap) begin
            if (!full || popr) mq.push_back(cur_rec());
            else if (bus.ctl_wrap_i && (m_k == 0)) begin
               void'(mq.pop_front());
               mq.push_back(cur_rec());
            end else if (m_drops < (1 << DW) - 1) m_drops++;
         end
         if (hs) m_k = popr ? 0 : m_k + 1;
         if (cap && (m_state == 1) && bus.ctl_trig_en_i &&
             (bus.rvfi_pc_rdata_i == bus.ctl_trig_pc_i)) begin
            m_trig = 1;
            if (bus.ctl_post_cnt_i == 0) m_state = 3;
            else begin
               m_post  = int'(bus.ctl_post_cnt_i);
               m_state = 2;
            end
         end else if (cap && (m_state == 2)) begin
            m_post--;
            if (m_post == 0) m_state = 3;
         end
      end
   endtask

   task automatic compare_all();
      check("m_count", bus.count_o, mq.size());
      check("m_drops", bus.drop_cnt_o, m_drops);
      check("m_state", bus.state_o, m_state);
      check("m_trig", bus.triggered_o, m_trig);
      check("m_valid", bus.out_valid_o, m_valid());
      if (m_valid()) begin
         check("m_data", bus.out_data_o, m_beat());
         check("m_last", bus.out_last_o, m_k == BPR - 1);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_rvfi(input logic [31:0] pc, input logic [63:0] order);
      bus.rvfi_pc_rdata_i = pc;
      bus.rvfi_order_i    = order;
      bus.rvfi_insn_i     = $urandom;
      bus.rvfi_rd_wdata_i = $urandom;
      bus.rvfi_rd_addr_i  = 5'($urandom);
      bus.rvfi_mode_i     = 2'($urandom);
      bus.rvfi_trap_i     = 1'($urandom);
      bus.rvfi_halt_i     = 1'($urandom);
      bus.rvfi_intr_i     = 1'($urandom);
   endtask

   task automatic retire(input logic [31:0] pc, input logic [63:0] order);
      set_rvfi(pc, order);
      bus.rvfi_valid_i = 1'b1;
      step();
      bus.rvfi_valid_i = 1'b0;
   endtask

   task automatic start_cap(input logic wrap, input logic trig_en, input logic [31:0] tpc,
                            input int post);
      bus.ctl_wrap_i     = wrap;
      bus.ctl_trig_en_i  = trig_en;
      bus.ctl_trig_pc_i  = tpc;
      bus.ctl_post_cnt_i = 4'(post);
      bus.ctl_start_i    = 1'b1;
      step();
      bus.ctl_start_i = 1'b0;
   endtask

   logic [31:0] held;
   int ready_pct;

   initial begin
      bus.rvfi_valid_i = 1'b0;
      set_rvfi(32'h0, 64'h0);
      bus.ctl_start_i    = 1'b0;
      bus.ctl_wrap_i     = 1'b0;
      bus.ctl_trig_en_i  = 1'b0;
      bus.ctl_trig_pc_i  = 32'h0;
      bus.ctl_post_cnt_i = '0;
      bus.out_ready_i    = 1'b0;

      step();
      check("rst_valid", bus.out_valid_o, 1'b0);
      check("rst_data", bus.out_data_o, 32'h0);
      check("rst_state", bus.state_o, 2'd0);
      rst_n = 1'b1;
      step();

      // stream and drain
      start_cap(1'b0, 1'b0, 32'h0, 0);
      retire(32'h100, 64'd0); retire(32'h104, 64'd1); retire(32'h108, 64'd2);
      check("t1_count", bus.count_o, 3);
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) check("t1_beat0", bus.out_data_o, 32'h100);
         if (i == 4) check("t1_beat4", bus.out_data_o, 32'h104);
         check("t1_last", bus.out_last_o, (i % 4) == 3);
         step();
      end
      bus.out_ready_i = 1'b0;
      check("t1_empty", bus.count_o, 0);

      // stop-when-full
      start_cap(1'b0, 1'b0, 32'h0, 0);
      for (int i = 0; i < 10; i++) retire(32'h1000 + 32'(4 * i), 64'(i));
      check("t2_count", bus.count_o, 8);
      check("t2_drops", bus.drop_cnt_o, 2);
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if ((i % 4) == 3) check("t2_order", bus.out_data_o[21:0], i / 4);
         step();
      end
      bus.out_ready_i = 1'b0;

      // wrap
      start_cap(1'b1, 1'b0, 32'h0, 0);
      for (int i = 0; i < 10; i++) retire(32'h1000 + 32'(4 * i), 64'(i));
      check("t3_count", bus.count_o, 8);
      check("t3_drops", bus.drop_cnt_o, 0);
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i == 3) check("t3_first_order", bus.out_data_o[21:0], 2);
         step();
      end
      bus.out_ready_i = 1'b0;

      // trigger with post count
      start_cap(1'b0, 1'b1, 32'h200, 2);
      retire(32'h1F8, 64'd10); retire(32'h1FC, 64'd11);
      check("t4_pre_trig", bus.triggered_o, 1'b0);
      retire(32'h200, 64'd12);
      check("t4_trig", bus.triggered_o, 1'b1);
      check("t4_post", bus.state_o, 2'd2);
      retire(32'h204, 64'd13); retire(32'h208, 64'd14);
      check("t4_done", bus.state_o, 2'd3);
      retire(32'h20C, 64'd15);
      check("t4_count", bus.count_o, 5);
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 16) check("t4_last_pc", bus.out_data_o, 32'h208);
         step();
      end
      bus.out_ready_i = 1'b0;

      // full push and pop, plus hold under back-pressure
      start_cap(1'b0, 1'b0, 32'h0, 0);
      for (int i = 0; i < 8; i++) retire(32'h3000 + 32'(4 * i), 64'(i));
      check("t5_full", bus.count_o, 8);
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      bus.out_ready_i = 1'b0;
      held = bus.out_data_o;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_hold", bus.out_data_o, held);
      end
      check("t5_last", bus.out_last_o, 1'b1);
      bus.out_ready_i = 1'b1;
      set_rvfi(32'hABC, 64'd99);
      bus.rvfi_valid_i = 1'b1;
      step();
      bus.rvfi_valid_i = 1'b0;
      check("t5_count", bus.count_o, 8);
      check("t5_drops", bus.drop_cnt_o, 0);
      for (int i = 0; i < 32; i++) begin
         if (i == 28) check("t5_new_last", bus.out_data_o, 32'hABC);
         step();
      end
      bus.out_ready_i = 1'b0;

      // reset in the middle of a record drain
      start_cap(1'b0, 1'b0, 32'h0, 0);
      for (int i = 0; i < 10; i++) retire(32'h4000 + 32'(4 * i), 64'(i));
      bus.out_ready_i = 1'b1;
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("t6_valid", bus.out_valid_o, 1'b0);
      check("t6_count", bus.count_o, 0);
      check("t6_state", bus.state_o, 2'd0);
      check("t6_drops", bus.drop_cnt_o, 0);
      check("t6_data", bus.out_data_o, 32'h0);
      bus.out_ready_i = 1'b0;

      // randomized traffic
      ready_pct = 50;
      for (int c = 0; c < 4000; c++) begin
         if ((c % 100) == 0) ready_pct = $urandom_range(0, 100);
         rst_n = ($urandom_range(0, 499) != 0);
         bus.ctl_start_i = ($urandom_range(0, 149) == 0);
         if (bus.ctl_start_i) begin
            bus.ctl_wrap_i     = 1'($urandom);
            bus.ctl_trig_en_i  = 1'($urandom);
            bus.ctl_trig_pc_i  = 32'h400;
            bus.ctl_post_cnt_i = 4'($urandom_range(0, 8));
         end
         if ($urandom_range(0, 299) == 0) bus.ctl_trig_en_i = ~bus.ctl_trig_en_i;
         set_rvfi(($urandom_range(0, 7) == 0) ? 32'h400 : {$urandom_range(0, 255), 2'b00},
                  {$urandom, $urandom});
         bus.rvfi_valid_i = 1'($urandom);
         bus.out_ready_i  = ($urandom_range(1, 100) <= ready_pct);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
